simple_serial_multi_core: RTL and testbench
===========================================

SIMPLE_SERIAL_MULTI_CORE -- requirements
Module: simple_serial_multi_core

Interface
REQ-001 The block SHALL have the parameters DATA_WIDTH, default 32, giving the maximum frame length in bits (legal range 1..32).
REQ-002 The block SHALL have the parameter NUM_CS, default 4, giving the number of chip-select channels (legal range 1..8).
REQ-003 The block SHALL have the parameter DIV_WIDTH, default 8, giving the width of the clock-divider field.
REQ-004 The block SHALL have these ports:
- axi_clk  in  1  sole clock; all logic is on the rising edge.
- axi_resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_data  in  DATA_WIDTH  transmit word, right-aligned.
- cmd_len  in  6  number of bits to transfer.
- cmd_cs_sel  in  3  chip-select index.
- cmd_lsb_first  in  1  selects bit order; 1 = LSB first.
- cmd_clk_div  in  DIV_WIDTH  half-period of sclk = cmd_clk_div+1 axi_clk cycles.
- rsp_valid  out  1  received word available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  received word, right-aligned.
- sclk  out  1  serial clock, idles low.
- cs_b  out  NUM_CS  active-low chip selects.
- pico  out  1  serial data out.
- poci  in  1  serial data in.
- dbg_status  out  3  state code.
- dbg_current_bit  out  6  count of bits sampled so far.

Function
REQ-005 The state machine SHALL have the states IDLE(0), SETUP(1), SHIFT(2), HOLD(3) and DONE(4), and dbg_status SHALL equal the current state code.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1, and the block SHALL enter SETUP on that edge.
REQ-007 On acceptance, the block SHALL latch all cmd_* fields; later changes to the cmd_* inputs SHALL NOT affect the transfer in progress.
REQ-008 The effective length L SHALL be cmd_len, except that cmd_len=0 or cmd_len>DATA_WIDTH SHALL give L=DATA_WIDTH.
REQ-009 H SHALL be cmd_clk_div+1; cmd_clk_div=0 SHALL give H=1, so sclk runs at axi_clk/2.
REQ-010 SETUP SHALL last H cycles, with cs_b[sel]=0, sclk=0, and pico driven with the first bit (cmd_data[L-1] if MSB first, cmd_data[0] if LSB first).
REQ-011 SHIFT SHALL produce L sclk pulses, each H cycles high then H cycles low.
REQ-012 poci SHALL be sampled on each sclk rising transition, and dbg_current_bit SHALL increment at that transition.
REQ-013 pico SHALL advance to the next bit on each sclk falling transition, except the last one.
REQ-014 HOLD SHALL last H cycles with sclk=0 and cs_b[sel] still 0; after HOLD the block SHALL enter DONE.
REQ-015 In DONE, cs_b SHALL be all ones and rsp_valid SHALL be 1.
REQ-016 rsp_valid SHALL first assert exactly (2L+2)*H rising edges after the accepting edge.
REQ-017 rsp_valid and rsp_data SHALL hold until the edge where rsp_ready=1, after which the block SHALL return to IDLE with rsp_valid=0.
REQ-018 rsp_data SHALL be right-aligned with unused upper bits 0.
- MSB first: the first sampled bit lands at bit L-1.
- LSB first: the i-th sampled bit (i from 0) lands at bit i.
REQ-019 rsp_data SHALL retain its value after the handshake until the next DONE.
REQ-020 If cmd_cs_sel>=NUM_CS, no cs_b bit SHALL assert, while the shift and response SHALL proceed normally.
REQ-021 At most one cs_b bit SHALL be low at any time; sclk SHALL be 0 in IDLE, SETUP, HOLD and DONE.
REQ-022 pico SHALL be 0 in IDLE and DONE.
REQ-023 dbg_current_bit SHALL be 0 in IDLE and SETUP and SHALL equal L in HOLD and DONE.

Reset
REQ-024 When axi_resetn=0, the block SHALL immediately, without waiting for a clock edge, force: state IDLE, cs_b all ones, sclk=0, pico=0, rsp_valid=0, rsp_data=0, dbg_current_bit=0, dbg_status=0.
REQ-025 cmd_ready SHALL be 0 while axi_resetn=0 and 1 from the first edge after release.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no response generated.

Verification
REQ-027 The bench SHALL cover the MSB-first loopback: poci tied to pico, data=0xA5, len=8, cs_sel=1, clk_div=0 -> cs_b=4'b1101 during transfer, 8 sclk pulses, rsp_valid at edge 18, rsp_data=0x000000A5.
REQ-028 The bench SHALL cover LSB first with poci driven by a model: device returns 0x3C LSB first, len=8, clk_div=3 -> each sclk phase lasts 4 cycles, rsp_valid at edge 72, rsp_data=0x3C.
REQ-029 The bench SHALL cover the len clamp: cmd_len=0 and cmd_len=40 with DATA_WIDTH=32 -> 32 sclk pulses each, dbg_current_bit=32 in DONE.
REQ-030 The bench SHALL cover an invalid chip select: cs_sel=6 with NUM_CS=4 -> cs_b stays 4'b1111 while 8 pulses are still generated and rsp_valid asserts.
REQ-031 The bench SHALL cover back-pressure: hold rsp_ready=0 for 20 cycles -> rsp_data stable, cmd_ready=0 throughout, IDLE on the edge after rsp_ready=1.
REQ-032 The bench SHALL cover reset mid-transfer: assert axi_resetn=0 after the 3rd sclk rise -> outputs take their reset values asynchronously, no rsp_valid, and the next command completes correctly.

Source files
------------

// File: rtl/simple_serial_multi_core_if.sv
// Command/response handshake bundle for the
// serial master engine.
interface simple_serial_multi_core_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [5:0]            cmd_len;
  logic [2:0]            cmd_cs_sel;
  logic                  cmd_lsb_first;
  logic [DIV_WIDTH-1:0]  cmd_clk_div;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_len,
    output cmd_cs_sel, cmd_lsb_first,
    output cmd_clk_div, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_len,
    input  cmd_cs_sel, cmd_lsb_first,
    input  cmd_clk_div, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/simple_serial_multi_core.sv
// Serial master: one command in, one framed
// full-duplex transfer out, one response back.
module simple_serial_multi_core #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic              axi_clk,
  input  logic              axi_resetn,
  simple_serial_multi_core_if.slave bus,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_b,
  output logic              pico,
  input  logic              poci,
  output logic [2:0]        dbg_status,
  output logic [5:0]        dbg_current_bit
);
  localparam int W = DATA_WIDTH;
  localparam logic [5:0] W6 = 6'(W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, div_q;
  logic [5:0]           len_q, bit_q;
  logic [2:0]           sel_q;
  logic                 lsb_q, sclk_q, pico_q, rdy_q;
  logic [W-1:0]         tx_q, rx_q, rsp_q;

  logic                 accept, phase_end, last_bit;
  logic                 active, first_bit, next_bit;
  logic [5:0]           len_eff;
  logic [W-1:0]         tx_init, tx_next, rx_next;

  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign phase_end = (cnt_q == div_q);
  assign last_bit  = (bit_q == len_q);
  assign active    = state_q inside {SETUP, SHIFT, HOLD};

  assign len_eff = (bus.cmd_len == 6'd0 || bus.cmd_len > W6)
                 ? W6 : bus.cmd_len;
  // MSB-first words are pre-aligned so the next bit is always the top bit
  assign tx_init = bus.cmd_lsb_first ? bus.cmd_data
                 : bus.cmd_data << (W - int'(len_eff));
  assign first_bit = bus.cmd_lsb_first ? tx_init[0] : tx_init[W-1];

  assign tx_next  = lsb_q ? tx_q >> 1 : tx_q << 1;
  assign next_bit = lsb_q ? tx_next[0] : tx_next[W-1];
  assign rx_next  = lsb_q
                  ? (rx_q >> 1) | (W'(poci) << (W - 1))
                  : (rx_q << 1) | W'(poci);

  assign bus.cmd_ready   = (state_q == IDLE) && rdy_q;
  assign bus.rsp_valid   = (state_q == DONE);
  assign bus.rsp_data    = rsp_q;
  assign sclk            = sclk_q;
  assign pico            = pico_q;
  assign dbg_status      = state_q;
  assign dbg_current_bit = bit_q;

  always_comb begin
    cs_b = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (active && sel_q == 3'(i)) cs_b[i] = 1'b0;
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (phase_end) state_d = SHIFT;
      SHIFT: if (phase_end && !sclk_q && last_bit)
               state_d = HOLD;
      HOLD:  if (phase_end) state_d = DONE;
      DONE:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rdy_q  <= 1'b0;
      cnt_q  <= '0;
      div_q  <= '0;
      len_q  <= '0;
      bit_q  <= '0;
      sel_q  <= '0;
      lsb_q  <= 1'b0;
      sclk_q <= 1'b0;
      pico_q <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
      rsp_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (active)
        cnt_q <= phase_end ? '0 : cnt_q + DIV_WIDTH'(1);
      unique case (state_q)
        IDLE: if (accept) begin
          cnt_q  <= '0;
          div_q  <= bus.cmd_clk_div;
          len_q  <= len_eff;
          sel_q  <= bus.cmd_cs_sel;
          lsb_q  <= bus.cmd_lsb_first;
          bit_q  <= '0;
          tx_q   <= tx_init;
          rx_q   <= '0;
          pico_q <= first_bit;
        end
        SETUP: if (phase_end) begin
          sclk_q <= 1'b1;
          rx_q   <= rx_next;
          bit_q  <= bit_q + 6'd1;
        end
        SHIFT: if (phase_end) begin
          if (sclk_q) begin
            sclk_q <= 1'b0;
            if (!last_bit) begin
              tx_q   <= tx_next;
              pico_q <= next_bit;
            end
          end else if (!last_bit) begin
            sclk_q <= 1'b1;
            rx_q   <= rx_next;
            bit_q  <= bit_q + 6'd1;
          end
        end
        HOLD: if (phase_end) begin
          pico_q <= 1'b0;
          rsp_q  <= lsb_q ? rx_q >> (W - int'(len_q)) : rx_q;
        end
        DONE: if (bus.rsp_ready) bit_q <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_simple_serial_multi_core.sv
// Directed vector bench for the serial master:
// loopback and device-model transfers plus resets.
module tb_simple_serial_multi_core;
  logic       axi_clk = 1'b0;
  logic       axi_resetn;
  logic       sclk, pico, poci;
  logic [3:0] cs_b;
  logic [2:0] dbg_status;
  logic [5:0] dbg_current_bit;

  int errors = 0;
  int checks = 0;

  simple_serial_multi_core_if #(
    .DATA_WIDTH(32), .DIV_WIDTH(8)
  ) bus ();

  simple_serial_multi_core #(
    .DATA_WIDTH(32), .NUM_CS(4), .DIV_WIDTH(8)
  ) dut (
    .axi_clk(axi_clk),
    .axi_resetn(axi_resetn),
    .bus(bus),
    .sclk(sclk),
    .cs_b(cs_b),
    .pico(pico),
    .poci(poci),
    .dbg_status(dbg_status),
    .dbg_current_bit(dbg_current_bit)
  );

  always #5 axi_clk = ~axi_clk;

  // Peripheral model: loopback or a shift-out device
  logic        loop_mode = 1'b1;
  logic        dev_msb = 1'b0;
  logic [31:0] dev_word = '0;
  int          dev_len = 0;
  int          neg_cnt = 0;
  int          dev_base = 0;

  always @(negedge sclk) neg_cnt <= neg_cnt + 1;

  always_comb begin
    int idx;
    logic [31:0] tmp;
    idx = neg_cnt - dev_base;
    tmp = '0;
    if (idx >= 0 && idx < dev_len)
      tmp = dev_word >> (dev_msb ? dev_len - 1 - idx : idx);
    poci = loop_mode ? pico : tmp[0];
  end

  typedef struct {
    logic [31:0] data;
    logic [5:0]  len;
    logic [2:0]  cs;
    logic        lsb;
    logic [7:0]  div;
    logic        loopback;
    logic [31:0] dev_word;
    int          dev_len;
    logic        dev_msb;
    int          exp_l;
    logic [3:0]  exp_cs_b;
    logic [31:0] exp_rsp;
    int          exp_edge;
    int          hold;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int n);
    int edges, rises, cs_bad, hold_bad;
    logic prev, first;
    logic [31:0] d;
    string tag;
    tag = $sformatf("v%0d", n);
    d = v.data;
    first = v.lsb ? d[0] : d[v.exp_l-1];
    loop_mode = v.loopback;
    dev_word = v.dev_word;
    dev_len = v.dev_len;
    dev_msb = v.dev_msb;
    dev_base = neg_cnt;
    chk({tag, " ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data = v.data;
    bus.cmd_len = v.len;
    bus.cmd_cs_sel = v.cs;
    bus.cmd_lsb_first = v.lsb;
    bus.cmd_clk_div = v.div;
    bus.rsp_ready = 1'b0;
    @(posedge axi_clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = ~v.data;
    bus.cmd_len = 6'd7;
    bus.cmd_cs_sel = 3'd0;
    bus.cmd_lsb_first = ~v.lsb;
    bus.cmd_clk_div = 8'd0;
    chk({tag, " setup_state"},
        {dbg_current_bit, 23'd0, dbg_status},
        {6'd0, 23'd0, 3'd1});
    chk({tag, " first_bit"}, 32'(pico), 32'(first));
    edges = 0;
    rises = 0;
    cs_bad = 0;
    prev = sclk;
    if (cs_b !== v.exp_cs_b) cs_bad++;
    while (!bus.rsp_valid && edges < 2000) begin
      @(posedge axi_clk);
      #1;
      edges++;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (edges < v.exp_edge && cs_b !== v.exp_cs_b)
        cs_bad++;
    end
    chk({tag, " rsp_edge"}, edges, v.exp_edge);
    chk({tag, " pulses"}, rises, v.exp_l);
    chk({tag, " cs_during"}, cs_bad, 0);
    chk({tag, " done_bits"}, 32'(dbg_current_bit), v.exp_l);
    chk({tag, " rsp_data"}, bus.rsp_data, v.exp_rsp);
    chk({tag, " done_pins"},
        {dbg_status, cs_b, sclk, pico},
        {3'd4, 4'b1111, 1'b0, 1'b0});
    hold_bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge axi_clk);
      #1;
      if (!bus.rsp_valid || bus.cmd_ready ||
          bus.rsp_data !== v.exp_rsp)
        hold_bad++;
    end
    if (v.hold > 0) chk({tag, " backpressure"}, hold_bad, 0);
    bus.rsp_ready = 1'b1;
    @(posedge axi_clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({tag, " back_idle"},
        {dbg_status, bus.rsp_valid, bus.cmd_ready, dbg_current_bit},
        {3'd0, 1'b0, 1'b1, 6'd0});
    chk({tag, " rsp_kept"}, bus.rsp_data, v.exp_rsp);
  endtask

  initial begin
    vec_t v;
    int rises, guard, bad;
    logic prev;
    vecs[0] = '{32'hA5, 6'd8, 3'd1, 1'b0, 8'd0, 1'b1,
                32'h0, 0, 1'b0, 8, 4'b1101, 32'hA5, 18, 20};
    vecs[1] = '{32'h5A, 6'd8, 3'd0, 1'b1, 8'd3, 1'b0,
                32'h3C, 8, 1'b0, 8, 4'b1110, 32'h3C, 72, 0};
    vecs[2] = '{32'h0, 6'd0, 3'd2, 1'b0, 8'd0, 1'b0,
                32'hDEADBEEF, 32, 1'b1, 32, 4'b1011,
                32'hDEADBEEF, 66, 0};
    vecs[3] = '{32'h0, 6'd40, 3'd3, 1'b1, 8'd1, 1'b0,
                32'h12345678, 32, 1'b0, 32, 4'b0111,
                32'h12345678, 132, 0};
    vecs[4] = '{32'hC3, 6'd8, 3'd6, 1'b1, 8'd0, 1'b1,
                32'h0, 0, 1'b0, 8, 4'b1111, 32'hC3, 18, 0};
    vecs[5] = '{32'h0, 6'd5, 3'd0, 1'b0, 8'd2, 1'b0,
                32'h16, 5, 1'b1, 5, 4'b1110, 32'h16, 36, 0};
    vecs[6] = '{32'hFFFFFABC, 6'd12, 3'd1, 1'b1, 8'd0, 1'b1,
                32'h0, 0, 1'b0, 12, 4'b1101, 32'hABC, 26, 0};

    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    bus.cmd_len = '0;
    bus.cmd_cs_sel = '0;
    bus.cmd_lsb_first = 1'b0;
    bus.cmd_clk_div = '0;
    bus.rsp_ready = 1'b0;
    axi_resetn = 1'b0;
    #1;
    chk("reset_pins",
        {dbg_status, cs_b, sclk, pico, bus.rsp_valid,
         bus.cmd_ready, dbg_current_bit},
        {3'd0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
    chk("reset_rsp", bus.rsp_data, 32'd0);
    repeat (3) @(posedge axi_clk);
    chk("ready_in_reset", 32'(bus.cmd_ready), 32'd0);
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    @(posedge axi_clk);
    #1;
    chk("ready_after_rel", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run(vecs[i], i);

    // Abort after the third sclk rise
    loop_mode = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 32'hA5;
    bus.cmd_len = 6'd8;
    bus.cmd_cs_sel = 3'd1;
    bus.cmd_lsb_first = 1'b0;
    bus.cmd_clk_div = 8'd2;
    @(posedge axi_clk);
    #1;
    bus.cmd_valid = 1'b0;
    rises = 0;
    guard = 0;
    prev = sclk;
    while (rises < 3 && guard < 200) begin
      @(posedge axi_clk);
      #1;
      guard++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    chk("abort_rises", rises, 3);
    #2;
    axi_resetn = 1'b0;
    #1;
    chk("abort_pins",
        {dbg_status, cs_b, sclk, pico, bus.rsp_valid,
         bus.cmd_ready, dbg_current_bit},
        {3'd0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
    chk("abort_rsp", bus.rsp_data, 32'd0);
    bad = 0;
    repeat (4) begin
      @(posedge axi_clk);
      #1;
      if (bus.rsp_valid) bad++;
    end
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    repeat (3) begin
      @(posedge axi_clk);
      #1;
      if (bus.rsp_valid) bad++;
    end
    chk("abort_no_rsp", bad, 0);
    v = vecs[0];
    v.hold = 0;
    run(v, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
